// File: rtl/moon_wave_if.sv
// Bundle between game-state logic and the moon wave controller.
// master: game side (frame tick, start/over, collisions).
// slave:  the wave controller driving the moon slots.
interface moon_wave_if #(
  parameter int N_MOONS = 4
);
  logic               tick;
  logic               game_start;
  logic               game_over;
  logic [N_MOONS-1:0] hit;
  logic [N_MOONS-1:0] offscreen;
  logic [N_MOONS-1:0] moon_en;
  logic [N_MOONS-1:0] moon_load;
  logic [25:0]        speed_offset;
  logic [3:0]         wave;
  logic [7:0]         kills;
  logic               wave_done;
  logic               frozen;

  modport master (
    output tick, game_start, game_over, hit, offscreen,
    input  moon_en, moon_load, speed_offset, wave, kills, wave_done, frozen
  );

  modport slave (
    input  tick, game_start, game_over, hit, offscreen,
    output moon_en, moon_load, speed_offset, wave, kills, wave_done, frozen
  );
endinterface

// File: rtl/moon_wave_ctrl.sv
// Moon wave sequencer: spawns moons into free slots at a fixed tick gap,
// retires them on hit/off-screen, pauses between waves and speeds moons up.

// One moon slot: active flag plus a one-cycle reload pulse on spawn.
module moon_wave_slot (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic retire,
  input  logic spawn,
  output logic en,
  output logic load
);
  // Spawn wins over a same-cycle retire so a freed slot can be reused at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      load <= 1'b0;
    end else begin
      load <= spawn;
      if (clr)         en <= 1'b0;
      else if (spawn)  en <= 1'b1;
      else if (retire) en <= 1'b0;
    end
  end
endmodule

module moon_wave_ctrl #(
  parameter int          N_MOONS        = 4,
  parameter int          MOONS_PER_WAVE = 6,
  parameter int          SPAWN_GAP      = 30,
  parameter int          CLEAR_TICKS    = 60,
  parameter logic [25:0] BASE_OFFSET    = 26'd2000000,
  parameter logic [25:0] SPEED_STEP     = 26'd200000,
  parameter logic [25:0] MIN_OFFSET     = 26'd400000
) (
  input  logic       clk,
  input  logic       reset,
  moon_wave_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SPAWN, RUN, CLEAR, HALT} state_t;

  localparam logic [7:0]  GAP_LAST   = 8'(SPAWN_GAP - 1);
  localparam logic [7:0]  CLR_LAST   = 8'(CLEAR_TICKS - 1);
  localparam logic [7:0]  LAST_SPAWN = 8'(MOONS_PER_WAVE - 1);
  // Offsets at or above this can take a full step without crossing the floor.
  localparam logic [26:0] STEP_FLOOR = {1'b0, MIN_OFFSET} + {1'b0, SPEED_STEP};

  state_t             state_q, state_d;
  logic [7:0]         gap_q, gap_d, clr_q, clr_d, spawned_q, spawned_d;
  logic               pend_q, pend_d;
  logic [25:0]        off_q, off_d, off_next;
  logic [3:0]         wave_q, wave_d;
  logic [7:0]         kills_q, kills_d, kills_sat;
  logic               done_q, done_d, frz_q, frz_d;
  logic               play, due, do_spawn, clr_all;
  logic [N_MOONS-1:0] en, load, retire, hits, free, pick, spawn_oh;
  logic [8:0]         ksum;

  // Retirement, kill count and lowest-index free slot for this cycle.
  always_comb begin
    play   = (state_q == SPAWN || state_q == RUN) && !bus.game_over;
    retire = play ? (en & (bus.hit | bus.offscreen)) : '0;
    hits   = play ? (en & bus.hit) : '0;
    free   = ~en | retire;
    ksum   = {1'b0, kills_q};
    for (int i = 0; i < N_MOONS; i++) ksum = ksum + 9'(hits[i]);
    kills_sat = (ksum > 9'd255) ? 8'd255 : ksum[7:0];
    pick = '0;
    for (int i = N_MOONS - 1; i >= 0; i--) if (free[i]) pick = N_MOONS'(1) << i;
    off_next = ({1'b0, off_q} >= STEP_FLOOR) ? (off_q - SPEED_STEP) : MIN_OFFSET;
  end

  // Next-state and datapath decisions; game_over outranks everything in play.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    clr_d     = clr_q;
    spawned_d = spawned_q;
    pend_d    = pend_q;
    off_d     = off_q;
    wave_d    = wave_q;
    kills_d   = kills_q;
    done_d    = 1'b0;
    frz_d     = frz_q;
    do_spawn  = 1'b0;
    clr_all   = 1'b0;
    due       = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (bus.game_start) begin
          clr_all   = 1'b1;
          state_d   = SPAWN;
          wave_d    = 4'd1;
          off_d     = BASE_OFFSET;
          spawned_d = '0;
          gap_d     = '0;
          clr_d     = '0;
          pend_d    = 1'b0;
          kills_d   = '0;
          frz_d     = 1'b0;
        end
      end
      SPAWN: begin
        if (bus.game_over) begin
          state_d = HALT;
          frz_d   = 1'b1;
        end else begin
          kills_d = kills_sat;
          // A pending spawn freezes the gap counter until a slot frees.
          if (!pend_q && bus.tick) gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + 8'd1;
          due = pend_q || (bus.tick && gap_q == GAP_LAST);
          if (due) begin
            if (|free) begin
              do_spawn  = 1'b1;
              pend_d    = 1'b0;
              spawned_d = spawned_q + 8'd1;
              if (spawned_q == LAST_SPAWN) state_d = RUN;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (bus.game_over) begin
          state_d = HALT;
          frz_d   = 1'b1;
        end else begin
          kills_d = kills_sat;
          if (en == '0) begin
            done_d  = 1'b1;
            clr_d   = '0;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        if (bus.game_over) begin
          state_d = HALT;
          frz_d   = 1'b1;
        end else if (bus.tick) begin
          if (clr_q == CLR_LAST) begin
            wave_d    = (wave_q == 4'd15) ? wave_q : wave_q + 4'd1;
            off_d     = off_next;
            spawned_d = '0;
            gap_d     = '0;
            pend_d    = 1'b0;
            state_d   = SPAWN;
          end else begin
            clr_d = clr_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    spawn_oh = do_spawn ? pick : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      clr_q     <= '0;
      spawned_q <= '0;
      pend_q    <= 1'b0;
      off_q     <= BASE_OFFSET;
      wave_q    <= '0;
      kills_q   <= '0;
      done_q    <= 1'b0;
      frz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      clr_q     <= clr_d;
      spawned_q <= spawned_d;
      pend_q    <= pend_d;
      off_q     <= off_d;
      wave_q    <= wave_d;
      kills_q   <= kills_d;
      done_q    <= done_d;
      frz_q     <= frz_d;
    end
  end

  for (genvar g = 0; g < N_MOONS; g++) begin : g_slot
    moon_wave_slot u_slot (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_all),
      .retire (retire[g]),
      .spawn  (spawn_oh[g]),
      .en     (en[g]),
      .load   (load[g])
    );
  end

  assign bus.moon_en      = en;
  assign bus.moon_load    = load;
  assign bus.speed_offset = off_q;
  assign bus.wave         = wave_q;
  assign bus.kills        = kills_q;
  assign bus.wave_done    = done_q;
  assign bus.frozen       = frz_q;
endmodule

// File: tb/tb_moon_wave_ctrl.sv
// Bench for moon_wave_ctrl: directed scenarios with literal expectations
// plus randomized play compared every cycle against a behavioural model.
module tb_moon_wave_ctrl;
  localparam int M_IDLE = 0, M_SPAWN = 1, M_RUN = 2, M_CLEAR = 3, M_HALT = 4;

  typedef struct {
    int         mode;
    logic [3:0] en;
    logic [3:0] load;
    int         off;
    int         wave;
    int         kills;
    bit         done;
    bit         frz;
    int         ticks;    // ticks seen since the last spawn slot opened
    int         spawned;
    bit         pend;
    int         clrc;
  } mdl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  mdl_t m;

  moon_wave_if #(.N_MOONS(4)) ifc ();

  moon_wave_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic mdl_t fresh();
    mdl_t f;
    f.mode = M_IDLE; f.en = '0; f.load = '0; f.off = 2000000; f.wave = 0;
    f.kills = 0; f.done = 0; f.frz = 0; f.ticks = 0; f.spawned = 0;
    f.pend = 0; f.clrc = 0;
    return f;
  endfunction

  // One clock of game rules applied to the model.
  function automatic mdl_t step(mdl_t c, bit tk, bit gs, bit go,
                                logic [3:0] h, logic [3:0] o);
    mdl_t n = c;
    bit due = 0;
    n.load = '0;
    n.done = 0;
    if (c.mode == M_IDLE || c.mode == M_HALT) begin
      if (gs) begin
        n = fresh();
        n.mode = M_SPAWN;
        n.wave = 1;
      end
      return n;
    end
    if (go) begin
      n.mode = M_HALT;
      n.frz = 1;
      return n;
    end
    if (c.mode != M_CLEAR)
      for (int i = 0; i < 4; i++)
        if (c.en[i] && (h[i] || o[i])) begin
          n.en[i] = 1'b0;
          if (h[i] && n.kills < 255) n.kills++;
        end
    case (c.mode)
      M_SPAWN: begin
        if (c.pend) due = 1;
        else if (tk) begin
          n.ticks = c.ticks + 1;
          if (n.ticks == 30) begin n.ticks = 0; due = 1; end
        end
        if (due) begin
          n.pend = 1;
          for (int i = 0; i < 4; i++)
            if (n.pend && !n.en[i]) begin
              n.en[i] = 1'b1; n.load[i] = 1'b1; n.pend = 0;
            end
          if (!n.pend) begin
            n.spawned++;
            if (n.spawned == 6) n.mode = M_RUN;
          end
        end
      end
      M_RUN: if (c.en == '0) begin n.done = 1; n.clrc = 0; n.mode = M_CLEAR; end
      M_CLEAR: if (tk) begin
        n.clrc = c.clrc + 1;
        if (n.clrc == 60) begin
          n.wave = (c.wave < 15) ? c.wave + 1 : 15;
          n.off = (c.off - 200000 < 400000) ? 400000 : c.off - 200000;
          n.spawned = 0; n.ticks = 0; n.pend = 0; n.mode = M_SPAWN;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  // Model advances on the same edges as the DUT, resetting asynchronously.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= fresh();
    else m <= step(m, ifc.tick, ifc.game_start, ifc.game_over, ifc.hit, ifc.offscreen);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, plus the offset-vs-wave rule.
  always @(negedge clk) begin
    chk("moon_en", ifc.moon_en, m.en);
    chk("moon_load", ifc.moon_load, m.load);
    chk("speed_offset", ifc.speed_offset, m.off);
    chk("wave", ifc.wave, m.wave);
    chk("kills", ifc.kills, m.kills);
    chk("wave_done", ifc.wave_done, m.done);
    chk("frozen", ifc.frozen, m.frz);
    if (m.wave > 0)
      chk("offset_rule", ifc.speed_offset,
          (2000000 - 200000 * (m.wave - 1) < 400000) ? 400000 : 2000000 - 200000 * (m.wave - 1));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ifc.tick = 0; ifc.game_start = 0; ifc.game_over = 0; ifc.hit = '0; ifc.offscreen = '0;
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin ifc.tick = 1; cyc(); cyc(); end
  endtask

  task automatic rnd_inputs(input bit allow_ctl);
    ifc.tick = ($urandom_range(1, 0) == 1);
    for (int i = 0; i < 4; i++) begin
      ifc.hit[i] = ($urandom_range(7, 0) == 0);
      ifc.offscreen[i] = ($urandom_range(15, 0) == 0);
    end
    if (allow_ctl) begin
      ifc.game_over = ($urandom_range(399, 0) == 0);
      ifc.game_start = ($urandom_range(299, 0) == 0);
    end
  endtask

  initial begin
    int budget;
    ifc.tick = 0; ifc.game_start = 0; ifc.game_over = 0; ifc.hit = '0; ifc.offscreen = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_wave", ifc.wave, 0);
    chk("rst_offset", ifc.speed_offset, 2000000);
    chk("rst_en", ifc.moon_en, 0);

    // First spawn one cycle after the 30th tick.
    ifc.game_start = 1; cyc();
    do_tick(29);
    chk("no_early_spawn", ifc.moon_en, 0);
    ifc.tick = 1; cyc();
    chk("first_load", ifc.moon_load, 4'b0001);
    chk("first_en", ifc.moon_en, 4'b0001);
    cyc();
    chk("load_one_cycle", ifc.moon_load, 0);
    do_tick(90);
    chk("all_full", ifc.moon_en, 4'b1111);

    // Fifth spawn waits for a slot; hit[2] frees it and it reloads in place.
    do_tick(30);
    chk("pending_no_load", ifc.moon_load, 0);
    cyc(); cyc();
    ifc.hit = 4'b0100; cyc();
    chk("pend_kills", ifc.kills, 1);
    chk("pend_en", ifc.moon_en, 4'b1111);
    chk("pend_load", ifc.moon_load, 4'b0100);

    // Freeze: ticks and hits change nothing; restart clears play.
    ifc.game_over = 1; cyc();
    chk("frozen", ifc.frozen, 1);
    repeat (100) begin
      ifc.tick = 1; ifc.hit = 4'($urandom); ifc.offscreen = 4'($urandom); cyc(); cyc();
    end
    chk("halt_en", ifc.moon_en, 4'b1111);
    chk("halt_kills", ifc.kills, 1);
    ifc.game_start = 1; cyc();
    chk("restart_en", ifc.moon_en, 0);
    chk("restart_kills", ifc.kills, 0);
    chk("restart_wave", ifc.wave, 1);
    chk("restart_frozen", ifc.frozen, 0);

    // Hit+offscreen on one slot is a single kill; inactive slot ignored.
    do_tick(30);
    ifc.hit = 4'b1001; ifc.offscreen = 4'b0001; cyc();
    chk("dual_en", ifc.moon_en, 0);
    chk("dual_kills", ifc.kills, 1);
    ifc.hit = 4'b1000; cyc();
    chk("inactive_kills", ifc.kills, 1);

    // Finish wave 1 with hits, then the clear pause.
    repeat (5) begin do_tick(30); ifc.hit = 4'hF; cyc(); end
    chk("wave1_kills", ifc.kills, 6);
    chk("done_not_yet", ifc.wave_done, 0);
    cyc();
    chk("wave_done", ifc.wave_done, 1);
    cyc();
    chk("wave_done_once", ifc.wave_done, 0);
    do_tick(59);
    chk("clear_wave1", ifc.wave, 1);
    do_tick(1);
    chk("wave2", ifc.wave, 2);
    chk("wave2_offset", ifc.speed_offset, 1800000);

    // Leave three moons up in RUN, then reset asynchronously mid-cycle.
    repeat (3) begin do_tick(30); ifc.hit = 4'hF; cyc(); end
    do_tick(3 * 30);
    chk("run_en", ifc.moon_en, 4'b0111);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_en", ifc.moon_en, 0);
    chk("async_wave", ifc.wave, 0);
    chk("async_kills", ifc.kills, 0);
    chk("async_offset", ifc.speed_offset, 2000000);
    @(posedge clk);
    #1 reset = 0;

    // Random play with occasional game_over / game_start.
    ifc.game_start = 1; cyc();
    repeat (3000) begin rnd_inputs(1); cyc(); end

    // Uninterrupted play until wave 15 has been held for a while.
    ifc.game_start = 1; cyc();
    budget = 40000;
    while (budget > 0 && !(m.wave == 15 && m.mode == M_RUN)) begin
      rnd_inputs(0); cyc(); budget--;
    end
    chk("reach_wave15", m.wave, 15);
    repeat (2000) begin rnd_inputs(0); cyc(); end
    chk("wave_sat", ifc.wave, 15);
    chk("offset_floor", ifc.speed_offset, 400000);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/moon_wave_ctrl.md
Name: moon_wave_ctrl

Overview:
- Sequences the moon enemy sprites wave by wave.
- Owns N_MOONS moon slots:
  - enables and reloads each slot at spawn time;
  - retires slots on hit or off-screen;
  - drives the shared speed_offset, which shrinks every wave so moons move faster.
- Sits between game-state logic (start/over, frame tick, collision) and the moon instances feeding the pixel mixer.

Parameters:
- N_MOONS, 4, number of moon slots (1..8).
- MOONS_PER_WAVE, 6, moons spawned per wave (1..255).
- SPAWN_GAP, 30, frame ticks between spawns (1..255).
- CLEAR_TICKS, 60, frame ticks of pause after a wave is cleared (1..255).
- BASE_OFFSET, 26'd2000000, speed_offset for wave 1.
- SPEED_STEP, 26'd200000, speed_offset decrement per wave.
- MIN_OFFSET, 26'd400000, speed_offset floor.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle pulse per frame (vsync)
- game_start  in  1  pulse: start or restart the game
- game_over  in  1  pulse: freeze play
- hit  in  N_MOONS  per-slot moon destroyed (level, sampled each cycle)
- offscreen  in  N_MOONS  per-slot moon left the playfield
- moon_en  out  N_MOONS  slot active (drives moon enable)
- moon_load  out  N_MOONS  one-cycle pulse: reload the slot's spawn position
- speed_offset  out  26  shared moon speed divider
- wave  out  4  current wave number, 0 when idle
- kills  out  8  moons destroyed, saturating
- wave_done  out  1  one-cycle pulse when a wave is cleared
- frozen  out  1  high in HALT

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-wave):
  - state=IDLE;
  - moon_en=0, moon_load=0, wave=0, kills=0, wave_done=0, frozen=0;
  - speed_offset=BASE_OFFSET;
  - internal counters cleared.
- States: IDLE, SPAWN, RUN, CLEAR, HALT.
- IDLE:
  - Waits for game_start.
  - On game_start: wave=1, speed_offset=BASE_OFFSET, spawned=0, gap_cnt=0; go to SPAWN.
- SPAWN:
  - Each tick increments gap_cnt.
  - When a tick arrives with gap_cnt==SPAWN_GAP-1, a spawn is due: gap_cnt->0.
  - On the next edge, the lowest-index free slot (moon_en[i]==0 after this cycle's retirements) gets moon_en[i]=1 and a 1-cycle moon_load[i] pulse; spawned++.
  - First spawn therefore follows the SPAWN_GAP-th tick after entry.
  - If no slot is free, the spawn stays pending (gap_cnt held at 0, no further counting) and is issued on the first cycle a slot frees.
  - When spawned==MOONS_PER_WAVE, go to RUN.
- Retirement, in SPAWN and RUN:
  - hit[i]|offscreen[i] with moon_en[i]=1 clears moon_en[i] on the next edge.
  - Only hit increments kills; saturate at 255.
  - hit and offscreen together count as one kill.
  - Inputs on inactive slots are ignored.
- Same-cycle retire and spawn target:
  - A retiring slot counts as free for a spawn in the same cycle.
  - Result: moon_en[i] stays 1 and moon_load[i] pulses.
- RUN: when moon_en==0, pulse wave_done for one cycle and go to CLEAR with clr_cnt=0.
- CLEAR:
  - Each tick increments clr_cnt.
  - On the tick with clr_cnt==CLEAR_TICKS-1:
    - wave = min(wave+1, 15);
    - speed_offset = max(speed_offset-SPEED_STEP, MIN_OFFSET), computed without unsigned underflow;
    - spawned=0, gap_cnt=0;
    - go to SPAWN.
- HALT:
  - game_over in SPAWN, RUN or CLEAR enters HALT next edge; frozen=1.
  - moon_en, wave, kills and speed_offset hold; tick, hit and offscreen are ignored.
  - game_over in IDLE or HALT is ignored.
- Restart: game_start in HALT performs the full IDLE start sequence in one edge:
  - moon_en=0, kills=0, wave=1, speed_offset=BASE_OFFSET, frozen=0;
  - go to SPAWN.
  - game_start in SPAWN, RUN or CLEAR is ignored.
- Priority within a cycle: reset > game_over > game_start > tick/hit/offscreen processing.
- Pulse rule: moon_load and wave_done are high for exactly one cycle, never two consecutive cycles for the same event.

Test Plan:
- Reset mid-RUN with moon_en=4'b0111 -> all outputs at reset values immediately (asynchronous), state IDLE, speed_offset=2000000.
- game_start, then 30 ticks -> exactly one moon_load=4'b0001 pulse one cycle after the 30th tick; moon_en=4'b0001; after 120 ticks moon_en=4'b1111.
- All 4 slots full when the 5th spawn is due; hit[2] asserted later -> kills=1; in the same cycle moon_en[2] stays 1 and moon_load=4'b0100 pulses.
- Wave of 6 cleared via hits/offscreen -> wave_done single pulse; after 60 ticks wave=2, speed_offset=1800000, SPAWN restarts; wave 9+ holds speed_offset=400000; wave saturates at 15.
- game_over during SPAWN -> frozen=1; 100 ticks plus hit pulses change nothing; game_start -> moon_en=0, kills=0, wave=1, frozen=0.
- Simultaneous hit[0] and offscreen[0] on an active slot -> moon_en[0] cleared, kills increments by exactly 1; hit[3] on an inactive slot -> no change.
